// File: rtl/mc_datapath_hs_if.sv
// Valid/ready memory bus between the multicycle datapath (master) and memory (slave).
// Address, write data and write strobe are held stable from request until mem_ready.
interface mc_datapath_hs_if #(
    parameter int XLEN = 32
);
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_ready;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mc_datapath_hs.sv
// Multicycle CPU datapath (PC, IR, DM, A/B/D, register file, ALU) driven by an external
// control FSM; memory goes through a valid/ready bus with an internal access FSM.
module mc_datapath_hs #(
    parameter int              XLEN      = 32,
    parameter int              NREGS     = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter bit              ZERO_REG0 = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_wr,
    input  logic             pc_cond,
    input  logic [1:0]       pc_wr_sel,
    input  logic             mem_go,
    input  logic             mem_adr_sel,
    input  logic             mem_we_ctl,
    input  logic             ir_wr,
    input  logic [3:0]       alu_op,
    input  logic             alu_a_sel,
    input  logic [1:0]       alu_b_sel,
    input  logic             reg_wr,
    input  logic             reg_data_sel,
    input  logic [1:0]       reg_w_sel,
    mc_datapath_hs_if.master mem,
    output logic             stall,
    output logic             mem_done,
    output logic [5:0]       opcode
);
    localparam int RA = $clog2(NREGS);

    typedef enum logic {IDLE, BUSY} acc_state_t;
    acc_state_t state, state_nxt;

    logic [XLEN-1:0] pc, dm, a_q, b_q, d_q;
    logic [31:0]     ir;
    logic [XLEN-1:0] rf [NREGS];

    logic [XLEN-1:0] addr_q, wdata_q;
    logic            we_q, tgt_ir_q, done_q;

    logic [RA-1:0]          rs1, rs2, rd, wsel;
    logic signed [XLEN-1:0] simm;
    logic [XLEN-1:0]        jump_tgt, rf_rs1, rf_rs2;
    logic [XLEN-1:0]        alu_a, alu_b, alu_y, pc_nxt, wr_data;
    logic                   pc_we, rf_we, accept, complete;

    function automatic logic [XLEN-1:0] flag(input logic c);
        return {{(XLEN-1){1'b0}}, c};
    endfunction

    function automatic logic [XLEN-1:0] alu_f(input logic [3:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa, sb;
        logic [4:0]             sh;
        sa = a;
        sb = b;
        sh = b[4:0];
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return flag(sa < sb);
            4'd6:    return flag(a < b);
            4'd7:    return a << sh;
            4'd8:    return a >> sh;
            4'd9:    return sa >>> sh;
            4'd10:   return flag(a == b);
            4'd11:   return flag(a != b);
            4'd12:   return flag(sa < sb);
            4'd13:   return flag(sa >= sb);
            default: return '0;
        endcase
    endfunction

    // Instruction fields; register addresses take the low RA bits of each 5-bit field.
    assign rs1      = ir[27 +: RA];
    assign rs2      = ir[22 +: RA];
    assign rd       = ir[17 +: RA];
    assign simm     = {{(XLEN-16){ir[21]}}, ir[21:6]};
    assign jump_tgt = {pc[XLEN-1:28], ir[31:6], 2'b00};
    assign opcode   = ir[5:0];

    assign rf_rs1 = (ZERO_REG0 && rs1 == '0) ? '0 : rf[rs1];
    assign rf_rs2 = (ZERO_REG0 && rs2 == '0) ? '0 : rf[rs2];

    assign alu_a = alu_a_sel ? a_q : pc;
    assign alu_y = alu_f(alu_op, alu_a, alu_b);

    always_comb begin
        alu_b   = b_q;
        wsel    = rd;
        pc_nxt  = alu_y;
        wr_data = reg_data_sel ? d_q : dm;
        case (alu_b_sel)
            2'd1:    alu_b = XLEN'(4);
            2'd2:    alu_b = simm;
            2'd3:    alu_b = simm <<< 2;
            default: alu_b = b_q;
        endcase
        case (reg_w_sel)
            2'd0:    wsel = rd;
            2'd1:    wsel = rs2;
            default: wsel = '1;
        endcase
        case (pc_wr_sel)
            2'd1:    pc_nxt = d_q;
            2'd2:    pc_nxt = jump_tgt;
            2'd3:    pc_nxt = RESET_PC;
            default: pc_nxt = alu_y;
        endcase
    end

    assign stall    = (state == BUSY);
    assign accept   = (state == IDLE) && mem_go;
    assign complete = (state == BUSY) && mem.mem_ready;
    assign pc_we    = !stall && (pc_wr || (pc_cond && alu_y == XLEN'(1)));
    assign rf_we    = reg_wr && !stall && !(ZERO_REG0 && wsel == '0);

    assign mem.mem_req   = stall;
    assign mem.mem_we    = stall && we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem_done      = done_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mem_go) state_nxt = BUSY;
            BUSY:    if (mem.mem_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Access request is captured at go; IR/DM load only when a read completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            tgt_ir_q <= 1'b0;
            done_q   <= 1'b0;
            ir       <= '0;
            dm       <= '0;
        end else begin
            done_q <= complete;
            if (accept) begin
                addr_q   <= mem_adr_sel ? d_q : pc;
                wdata_q  <= b_q;
                we_q     <= mem_we_ctl;
                tgt_ir_q <= ir_wr;
            end
            if (complete && !we_q) begin
                if (tgt_ir_q) ir <= mem.mem_rdata[31:0];
                else          dm <= mem.mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc  <= RESET_PC;
            a_q <= '0;
            b_q <= '0;
            d_q <= '0;
        end else if (!stall) begin
            a_q <= rf_rs1;
            b_q <= rf_rs2;
            d_q <= alu_y;
            if (pc_we) pc <= pc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (rf_we) begin
            rf[wsel] <= wr_data;
        end
    end
endmodule

// File: tb/tb_mc_datapath_hs.sv
// Directed bench for mc_datapath_hs: ALU vector table plus hand sequences for fetch,
// branches, writeback, stalled store and reset during an access.
module tb_mc_datapath_hs;
    logic       clk = 1'b0;
    logic       rst;
    logic       pc_wr, pc_cond, mem_go, mem_adr_sel, mem_we_ctl, ir_wr;
    logic [1:0] pc_wr_sel, alu_b_sel, reg_w_sel;
    logic [3:0] alu_op;
    logic       alu_a_sel, reg_wr, reg_data_sel;
    logic       stall, mem_done;
    logic [5:0] opcode;

    int checks;
    int failures;
    logic [31:0] exp_pc;

    mc_datapath_hs_if #(.XLEN(32)) bus ();

    mc_datapath_hs #(.XLEN(32), .NREGS(32), .RESET_PC(32'h0), .ZERO_REG0(1'b1)) dut (
        .clk(clk), .rst(rst),
        .pc_wr(pc_wr), .pc_cond(pc_cond), .pc_wr_sel(pc_wr_sel),
        .mem_go(mem_go), .mem_adr_sel(mem_adr_sel), .mem_we_ctl(mem_we_ctl), .ir_wr(ir_wr),
        .alu_op(alu_op), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .reg_wr(reg_wr), .reg_data_sel(reg_data_sel), .reg_w_sel(reg_w_sel),
        .mem(bus),
        .stall(stall), .mem_done(mem_done), .opcode(opcode)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } alu_vec_t;

    alu_vec_t vecs [17];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic ctl_idle();
        pc_wr = 0; pc_cond = 0; pc_wr_sel = 0;
        mem_go = 0; mem_adr_sel = 0; mem_we_ctl = 0; ir_wr = 0;
        alu_op = 0; alu_a_sel = 0; alu_b_sel = 0;
        reg_wr = 0; reg_data_sel = 0; reg_w_sel = 0;
    endtask

    // One bus transaction: go cycle, waits+1 BUSY cycles, ready on the last one.
    task automatic access(input logic we, input logic asel, input logic irw, input int waits,
                          input logic [31:0] rdata, input logic [31:0] exp_addr,
                          input logic [31:0] exp_wdata, input logic noise, input string nm);
        mem_go = 1; mem_we_ctl = we; mem_adr_sel = asel; ir_wr = irw;
        tick();
        mem_go = 0;
        if (noise) begin
            pc_wr = 1;
            reg_wr = 1;
        end
        for (int i = 0; i <= waits; i++) begin
            chk({nm, " req"}, {31'b0, bus.mem_req}, 32'd1);
            chk({nm, " stall"}, {31'b0, stall}, 32'd1);
            chk({nm, " addr"}, bus.mem_addr, exp_addr);
            chk({nm, " we"}, {31'b0, bus.mem_we}, {31'b0, we});
            if (we) chk({nm, " wdata"}, bus.mem_wdata, exp_wdata);
            if (i == waits) begin
                bus.mem_ready = 1;
                bus.mem_rdata = rdata;
            end
            tick();
        end
        bus.mem_ready = 0;
        pc_wr = 0;
        reg_wr = 0;
        chk({nm, " done"}, {31'b0, mem_done}, 32'd1);
        chk({nm, " req_drop"}, {31'b0, bus.mem_req}, 32'd0);
        chk({nm, " stall_drop"}, {31'b0, stall}, 32'd0);
    endtask

    task automatic load_ir(input logic [31:0] v, input int waits);
        access(1'b0, 1'b0, 1'b1, waits, v, exp_pc, 32'h0, 1'b0, "ld_ir");
    endtask

    task automatic load_dm(input logic [31:0] v, input int waits);
        access(1'b0, 1'b0, 1'b0, waits, v, exp_pc, 32'h0, 1'b0, "ld_dm");
    endtask

    // Register write through IR.rd and the DM path, using zero-wait back-to-back accesses.
    task automatic set_reg(input logic [4:0] r, input logic [31:0] v);
        load_ir({10'b0, r, 17'b0}, 0);
        load_dm(v, 0);
        reg_wr = 1; reg_data_sel = 0; reg_w_sel = 0;
        tick();
        ctl_idle();
    endtask

    logic [31:0] ir_c;

    initial begin
        checks = 0;
        failures = 0;
        exp_pc = 32'h0;
        ctl_idle();
        bus.mem_ready = 0;
        bus.mem_rdata = 32'h0;

        vecs[0]  = '{4'd0,  32'h0000_0007, 32'h0000_0005, 32'h0000_000C};
        vecs[1]  = '{4'd1,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE};
        vecs[2]  = '{4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
        vecs[3]  = '{4'd3,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0};
        vecs[4]  = '{4'd4,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0};
        vecs[5]  = '{4'd5,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
        vecs[6]  = '{4'd6,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[7]  = '{4'd7,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000};
        vecs[8]  = '{4'd7,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002};
        vecs[9]  = '{4'd8,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000};
        vecs[10] = '{4'd9,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000};
        vecs[11] = '{4'd10, 32'h0000_0005, 32'h0000_0005, 32'h0000_0001};
        vecs[12] = '{4'd11, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000};
        vecs[13] = '{4'd12, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0001};
        vecs[14] = '{4'd13, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0000};
        vecs[15] = '{4'd13, 32'h0000_0003, 32'h0000_0003, 32'h0000_0001};
        vecs[16] = '{4'd14, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000};

        // Reset state
        rst = 1;
        tick();
        tick();
        chk("rst mem_req", {31'b0, bus.mem_req}, 32'd0);
        chk("rst mem_we", {31'b0, bus.mem_we}, 32'd0);
        chk("rst mem_addr", bus.mem_addr, 32'h0);
        chk("rst mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst stall", {31'b0, stall}, 32'd0);
        chk("rst mem_done", {31'b0, mem_done}, 32'd0);
        chk("rst opcode", {26'b0, opcode}, 32'd0);
        chk("rst pc", dut.pc, 32'h0);
        rst = 0;

        // Fetch with a 3-cycle slave wait
        access(1'b0, 1'b0, 1'b1, 3, 32'h1234_5601, 32'h0, 32'h0, 1'b0, "fetch");
        chk("fetch ir", dut.ir, 32'h1234_5601);
        chk("fetch opcode", {26'b0, opcode}, 32'h01);
        tick();
        chk("fetch done_pulse", {31'b0, mem_done}, 32'd0);
        chk("fetch pc", dut.pc, 32'h0);

        // PC + 4, then jump
        alu_a_sel = 0; alu_b_sel = 1; alu_op = 0; pc_wr = 1; pc_wr_sel = 0;
        tick();
        ctl_idle();
        exp_pc = 32'h4;
        chk("pc_plus4", dut.pc, exp_pc);
        load_ir(32'h0000_0100, 1);
        pc_wr = 1; pc_wr_sel = 2;
        tick();
        ctl_idle();
        exp_pc = 32'h10;
        chk("pc_jump", dut.pc, exp_pc);

        // Conditional branch taken (A==B) to D
        set_reg(5'd1, 32'd5);
        set_reg(5'd2, 32'd5);
        ir_c = (32'd1 << 27) | (32'd2 << 22) | (32'h30 << 6);
        load_ir(ir_c, 0);
        tick();
        alu_a_sel = 0; alu_b_sel = 2; alu_op = 0;
        tick();
        chk("br d_pc_simm", dut.d_q, 32'h40);
        alu_a_sel = 1; alu_b_sel = 0; alu_op = 10; pc_cond = 1; pc_wr_sel = 1;
        tick();
        ctl_idle();
        exp_pc = 32'h40;
        chk("br taken pc", dut.pc, exp_pc);

        // Conditional branch not taken (A!=B)
        set_reg(5'd2, 32'd6);
        load_ir(ir_c, 0);
        tick();
        alu_a_sel = 0; alu_b_sel = 2; alu_op = 0;
        tick();
        chk("br2 d", dut.d_q, 32'h70);
        alu_a_sel = 1; alu_b_sel = 0; alu_op = 10; pc_cond = 1; pc_wr_sel = 1;
        tick();
        ctl_idle();
        chk("br not_taken pc", dut.pc, exp_pc);
        chk("br not_taken d", dut.d_q, 32'h0);

        // Writeback of D: -1 + simm(-1) into rd=31, then rf[1] + 0x1800 into rd=3
        set_reg(5'd1, 32'hFFFF_FFFF);
        load_ir((32'd1 << 27) | (32'hFFFF << 6), 0);
        tick();
        alu_a_sel = 1; alu_b_sel = 2; alu_op = 0;
        tick();
        chk("wb d_neg", dut.d_q, 32'hFFFF_FFFE);
        reg_wr = 1; reg_data_sel = 1; reg_w_sel = 0;
        tick();
        ctl_idle();
        chk("wb rf31", dut.rf[31], 32'hFFFF_FFFE);
        load_ir((32'd1 << 27) | (32'h1800 << 6), 0);
        tick();
        alu_a_sel = 1; alu_b_sel = 2; alu_op = 0;
        tick();
        reg_wr = 1; reg_data_sel = 1; reg_w_sel = 0;
        tick();
        ctl_idle();
        chk("wb rf3", dut.rf[3], 32'h0000_17FF);

        // Writes to reg0 are dropped and it reads 0
        set_reg(5'd0, 32'h55);
        load_ir(32'h0, 0);
        tick();
        chk("reg0 read", dut.a_q, 32'h0);

        // Link register write from DM
        load_dm(32'hCAFE_F00D, 1);
        reg_wr = 1; reg_data_sel = 0; reg_w_sel = 2;
        tick();
        ctl_idle();
        chk("link rf31", dut.rf[31], 32'hCAFE_F00D);

        // Same-cycle write/read of rs2: B sees the old value
        load_ir(32'd2 << 22, 0);
        load_dm(32'h22, 0);
        reg_wr = 1; reg_data_sel = 0; reg_w_sel = 1;
        tick();
        ctl_idle();
        chk("wr_rd b_old", dut.b_q, 32'd6);
        chk("wr_rd rf2", dut.rf[2], 32'h22);

        // Store to D=0x100 with 2 wait cycles; pc_wr/reg_wr during stall ignored
        set_reg(5'd2, 32'hDEAD_BEEF);
        ir_c = (32'd2 << 22) | (32'h100 << 6);
        load_ir(ir_c, 0);
        tick();
        alu_a_sel = 1; alu_b_sel = 2; alu_op = 0;
        tick();
        chk("st d", dut.d_q, 32'h100);
        pc_wr_sel = 1; reg_w_sel = 2; reg_data_sel = 1;
        access(1'b1, 1'b1, 1'b0, 2, 32'h1111_1111, 32'h100, 32'hDEAD_BEEF, 1'b1, "store");
        ctl_idle();
        chk("st pc_held", dut.pc, exp_pc);
        chk("st rf31_held", dut.rf[31], 32'hCAFE_F00D);
        chk("st dm_held", dut.dm, 32'hDEAD_BEEF);
        chk("st ir_held", dut.ir, ir_c);
        chk("st we_drop", {31'b0, bus.mem_we}, 32'd0);

        // ALU vector table
        for (int i = 0; i < 17; i++) begin
            set_reg(5'd1, vecs[i].a);
            set_reg(5'd2, vecs[i].b);
            load_ir((32'd1 << 27) | (32'd2 << 22), 0);
            tick();
            alu_a_sel = 1; alu_b_sel = 0; alu_op = vecs[i].op;
            tick();
            ctl_idle();
            chk($sformatf("alu[%0d] op%0d", i, vecs[i].op), dut.d_q, vecs[i].exp);
        end

        // Reset during BUSY abandons the access
        mem_go = 1; mem_adr_sel = 0; ir_wr = 1;
        tick();
        mem_go = 0;
        tick();
        chk("rmid req_busy", {31'b0, bus.mem_req}, 32'd1);
        rst = 1;
        tick();
        rst = 0;
        ctl_idle();
        chk("rmid req", {31'b0, bus.mem_req}, 32'd0);
        chk("rmid stall", {31'b0, stall}, 32'd0);
        chk("rmid ir", dut.ir, 32'h0);
        chk("rmid pc", dut.pc, 32'h0);
        bus.mem_ready = 1;
        bus.mem_rdata = 32'hABCD_0000;
        tick();
        chk("rmid done1", {31'b0, mem_done}, 32'd0);
        tick();
        chk("rmid done2", {31'b0, mem_done}, 32'd0);
        chk("rmid ir_after", dut.ir, 32'h0);
        bus.mem_ready = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
